// File: rtl/parking_pkg.sv
// Shared definitions for the parking-lot gate direction detectors:
// FSM state encoding and synchronized sensor-pair codes {a_s, b_s}.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    B_ONLY  = 3'd1,
    BOTH    = 3'd2,
    A_ONLY  = 3'd3,
    LOCKOUT = 3'd4
  } park_state_t;

  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_A    = 2'b10;
  localparam logic [1:0] S_AB   = 2'b11;

  // True for the states that belong to a car actually crossing the beams.
  function automatic logic is_mid(input park_state_t st);
    return (st == B_ONLY) || (st == BOTH) || (st == A_ONLY);
  endfunction

endpackage

// File: rtl/sensor_sync.sv
// Multi-flop synchronizer for a bus of independent asynchronous sensor bits.
// Each bit passes through STAGES flops; the chain clears on reset.
module sensor_sync #(
  parameter int STAGES = 2,
  parameter int W      = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/fsm_out.sv
// Exit-direction detector on the gate's outer (a) / inner (b) beam pair.
// Optional dwell timeout on mid-sequence states: define FSM_OUT_TIMEOUT_EN.
module fsm_out
  import parking_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             cnt_clr,
  output logic             exit_pulse,
  output logic             err_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] exit_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("fsm_out: SYNC_STAGES must be 2..3 and TIMEOUT_CYCLES at least 2");
  end

  logic [1:0]  s;
  park_state_t state;
  park_state_t state_nxt;
  logic        exit_nxt;
  logic        err_nxt;

  sensor_sync #(
    .STAGES (SYNC_STAGES),
    .W      (2)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({a, b}),
    .q     (s)
  );

`ifdef FSM_OUT_TIMEOUT_EN
  localparam int DWELL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [DWELL_W-1:0] dwell;
  logic               dwell_expired;

  assign dwell_expired = (dwell == DWELL_W'(TIMEOUT_CYCLES - 1));

  // Counts edges spent in the current crossing state; restarts on any change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell <= '0;
    end else if (state_nxt != state || !is_mid(state_nxt)) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    exit_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        case (s)
          S_B:     state_nxt = B_ONLY;
          S_AB:    begin state_nxt = LOCKOUT; err_nxt = 1'b1; end
          default: state_nxt = IDLE;  // S_A is an entering car, not ours
        endcase
      end
      B_ONLY: begin
        case (s)
          S_AB:    state_nxt = BOTH;
          S_NONE:  state_nxt = IDLE;
          S_A:     begin state_nxt = LOCKOUT; err_nxt = 1'b1; end
          default: state_nxt = B_ONLY;
        endcase
      end
      BOTH: begin
        case (s)
          S_A:     state_nxt = A_ONLY;
          S_B:     state_nxt = B_ONLY;
          S_NONE:  begin state_nxt = IDLE; err_nxt = 1'b1; end
          default: state_nxt = BOTH;
        endcase
      end
      A_ONLY: begin
        case (s)
          S_NONE:  begin state_nxt = IDLE; exit_nxt = 1'b1; end
          S_AB:    state_nxt = BOTH;
          S_B:     begin state_nxt = LOCKOUT; err_nxt = 1'b1; end
          default: state_nxt = A_ONLY;
        endcase
      end
      LOCKOUT: begin
        if (s == S_NONE) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef FSM_OUT_TIMEOUT_EN
    if (is_mid(state) && state_nxt == state && dwell_expired) begin
      state_nxt = LOCKOUT;
      err_nxt   = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      exit_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      busy       <= 1'b0;
      exit_count <= '0;
    end else begin
      state      <= state_nxt;
      exit_pulse <= exit_nxt;
      err_pulse  <= err_nxt;
      busy       <= (state_nxt != IDLE);
      // A clear wins over a coincident exit; the pulse itself still fires.
      if (cnt_clr) begin
        exit_count <= '0;
      end else if (exit_nxt && exit_count != CNT_MAX) begin
        exit_count <= exit_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fsm_out.sv
// Randomized self-checking bench for fsm_out against a table-driven
// reference model of the exit-detection rules.
module tb_fsm_out;

  localparam int SYNC  = 2;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // model phases: rest, inner beam only, both beams, outer beam only, jammed
  localparam int P_REST  = 0;
  localparam int P_INNER = 1;
  localparam int P_BOTH  = 2;
  localparam int P_OUTER = 3;
  localparam int P_JAM   = 4;
  localparam int EV_NONE = 0;
  localparam int EV_EXIT = 1;
  localparam int EV_ERR  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             a = 1'b0;
  logic             b = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             exit_pulse;
  logic             err_pulse;
  logic             busy;
  logic [CNT_W-1:0] exit_count;

  int total = 0;
  int bad   = 0;
  int n_exit = 0;
  int n_err  = 0;

  fsm_out #(
    .SYNC_STAGES    (SYNC),
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .cnt_clr    (cnt_clr),
    .exit_pulse (exit_pulse),
    .err_pulse  (err_pulse),
    .busy       (busy),
    .exit_count (exit_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int nxt_tbl [5][4];
  int ev_tbl  [5][4];
  int m_ph = P_REST;
  int m_cnt = 0;
  logic m_exit = 1'b0;
  logic m_err  = 1'b0;
  logic m_busy = 1'b0;
  logic [1:0] pipe [$];
  logic [1:0] m_s;

  task automatic rule(input int ph, input int ab, input int nx, input int ev);
    nxt_tbl[ph][ab] = nx;
    ev_tbl[ph][ab]  = ev;
  endtask

  task automatic build_rules();
    rule(P_REST,  0, P_REST,  EV_NONE); rule(P_REST,  1, P_INNER, EV_NONE);
    rule(P_REST,  2, P_REST,  EV_NONE); rule(P_REST,  3, P_JAM,   EV_ERR);
    rule(P_INNER, 0, P_REST,  EV_NONE); rule(P_INNER, 1, P_INNER, EV_NONE);
    rule(P_INNER, 2, P_JAM,   EV_ERR);  rule(P_INNER, 3, P_BOTH,  EV_NONE);
    rule(P_BOTH,  0, P_REST,  EV_ERR);  rule(P_BOTH,  1, P_INNER, EV_NONE);
    rule(P_BOTH,  2, P_OUTER, EV_NONE); rule(P_BOTH,  3, P_BOTH,  EV_NONE);
    rule(P_OUTER, 0, P_REST,  EV_EXIT); rule(P_OUTER, 1, P_JAM,   EV_ERR);
    rule(P_OUTER, 2, P_OUTER, EV_NONE); rule(P_OUTER, 3, P_BOTH,  EV_NONE);
    rule(P_JAM,   0, P_REST,  EV_NONE); rule(P_JAM,   1, P_JAM,   EV_NONE);
    rule(P_JAM,   2, P_JAM,   EV_NONE); rule(P_JAM,   3, P_JAM,   EV_NONE);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = P_REST; m_cnt = 0; m_exit = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      pipe.delete();
      for (int i = 0; i < SYNC; i++) pipe.push_back(2'b00);
    end else begin
      m_s    = pipe[0];
      m_exit = (ev_tbl[m_ph][m_s] == EV_EXIT);
      m_err  = (ev_tbl[m_ph][m_s] == EV_ERR);
      m_ph   = nxt_tbl[m_ph][m_s];
      m_busy = (m_ph != P_REST);
      if (cnt_clr) m_cnt = 0;
      else if (m_exit && m_cnt < CMAX) m_cnt = m_cnt + 1;
      void'(pipe.pop_front());
      pipe.push_back({a, b});
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    check("exit_pulse", exit_pulse, m_exit);
    check("err_pulse", err_pulse, m_err);
    check("busy", busy, m_busy);
    check("exit_count", exit_count, m_cnt);
    check("pulse_excl", exit_pulse & err_pulse, 0);
    if (exit_pulse) n_exit++;
    if (err_pulse) n_err++;
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [1:0] ab, input int n);
    {a, b} = ab;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_exit(input int hold, input logic clr_at_end);
    drive(2'b01, hold);
    drive(2'b11, hold);
    drive(2'b10, hold);
    cnt_clr = clr_at_end;
    drive(2'b00, 5);
    cnt_clr = 1'b0;
  endtask

  task automatic pulse_reset(input int low_cycles);
    #2 reset = 1'b0;
    repeat (low_cycles) @(negedge clk);
    reset = 1'b1;
  endtask

  int e0, r0;
  logic [1:0] rab;

  initial begin
    build_rules();
    repeat (3) @(negedge clk);
    #1;
    check("rst_exit", exit_pulse, 0);
    check("rst_err", err_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_count", exit_count, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(2'b00, 3);

    // normal exit with latency check
    e0 = n_exit; r0 = n_err;
    drive(2'b01, 5); drive(2'b11, 5); drive(2'b10, 5);
    {a, b} = 2'b00;
    repeat (SYNC) @(negedge clk);
    #1 check("norm_lat_early", exit_pulse, 0);
    @(negedge clk);
    #1 check("norm_lat", exit_pulse, 1);
    @(negedge clk);
    #1 check("norm_one_cycle", exit_pulse, 0);
    drive(2'b00, 3);
    check("norm_exits", n_exit - e0, 1);
    check("norm_errs", n_err - r0, 0);
    check("norm_count", exit_count, 1);

    // entry sequence: ignored until the jump to both beams from rest
    e0 = n_exit; r0 = n_err;
    drive(2'b10, 5); drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
    check("entry_exits", n_exit - e0, 0);
    check("entry_errs", n_err - r0, 1);
    check("entry_count", exit_count, 1);
    check("entry_idle", busy, 0);

    // back-out
    e0 = n_exit; r0 = n_err;
    drive(2'b01, 5); drive(2'b11, 5); drive(2'b01, 5); drive(2'b00, 5);
    check("backout_exits", n_exit - e0, 0);
    check("backout_errs", n_err - r0, 0);
    check("backout_idle", busy, 0);

    // illegal jump from both beams to none
    e0 = n_exit; r0 = n_err;
    drive(2'b01, 5); drive(2'b11, 5); drive(2'b00, 5);
    check("jump_exits", n_exit - e0, 0);
    check("jump_errs", n_err - r0, 1);
    check("jump_idle", busy, 0);

    // saturation then clear colliding with an exit
    cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) do_exit(3, 1'b0);
    check("sat_count", exit_count, CMAX);
    e0 = n_exit;
    do_exit(3, 1'b1);
    check("clr_exit_seen", n_exit - e0, 1);
    check("clr_count", exit_count, 0);

    // asynchronous reset while the outer beam alone is broken
    drive(2'b01, 5); drive(2'b11, 5); drive(2'b10, 5);
    check("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_exit", exit_pulse, 0);
    check("arst_err", err_pulse, 0);
    check("arst_busy", busy, 0);
    check("arst_count", exit_count, 0);
    {a, b} = 2'b00;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    e0 = n_exit;
    drive(2'b00, 8);
    check("arst_no_exit", n_exit - e0, 0);

    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      cnt_clr = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0, 1: begin
          drive(2'b01, $urandom_range(1, 4));
          drive(2'b11, $urandom_range(1, 4));
          if ($urandom_range(0, 3) == 0) drive(2'b01, $urandom_range(1, 3));
          drive(2'b10, $urandom_range(1, 4));
          drive(2'b00, $urandom_range(1, 4));
        end
        default: begin
          rab = 2'($urandom_range(0, 3));
          drive(rab, $urandom_range(1, 6));
        end
      endcase
      cnt_clr = 1'b0;
      if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 3));
    end
    drive(2'b00, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
